// File: rtl/if_pkg.sv
// Shared fetch-stage types and constants.
// Prefetch queue depth, NOP encoding and queue entry layout.
package if_pkg;
  localparam int IF_Q_DEPTH = 2;
  localparam int IF_INS_W = 32;
  localparam int IF_ADDR_W = 9;
  localparam logic [31:0] IF_NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [IF_INS_W-1:0]  inst;
    logic [IF_ADDR_W-1:0] pc;
  } if_entry_t;
endpackage

// File: rtl/if_prefetch_q.sv
// 2-entry prefetch FIFO with flush; pointers wrap mod 2.
// Ports: clk_i, rst_i, push_i, pop_i, flush_i, data_i, head_o, count_o.
module if_prefetch_q
  import if_pkg::*;
#(
  parameter int W = 41
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] head_o,
  output logic [1:0]   count_o
);
  logic [W-1:0] mem_q [IF_Q_DEPTH];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push_i) wr_ptr_d = ~wr_ptr_q;
      if (pop_i)  rd_ptr_d = ~rd_ptr_q;
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload needs no reset: it is only observed when count is non-zero.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns PC, reads imem, buffers in a 2-entry queue.
// Ports: clk, rst, imem_req/addr/rdata, stall, redirect_en/pc,
// INSTout, PCout, valid_out. Option macro: IF_BUBBLE_NOP_EN
// (invalid INSTout reads as NOP instead of zero).
module if_fetch_unit
  import if_pkg::*;
#(
  parameter int INS_ADDRESS = IF_ADDR_W,
  parameter int INS_W       = IF_INS_W
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req,
  output logic [INS_ADDRESS-1:0] imem_addr,
  input  logic [INS_W-1:0]       imem_rdata,
  input  logic                   stall,
  input  logic                   redirect_en,
  input  logic [INS_ADDRESS-1:0] redirect_pc,
  output logic [INS_W-1:0]       INSTout,
  output logic [INS_ADDRESS-1:0] PCout,
  output logic                   valid_out
);
  typedef struct packed {
    logic [INS_W-1:0]       inst;
    logic [INS_ADDRESS-1:0] pc;
  } entry_t;

  localparam logic [INS_ADDRESS-1:0] PC_ONE = INS_ADDRESS'(1);
  localparam logic [1:0] Q_FULL = 2'(IF_Q_DEPTH);
`ifdef IF_BUBBLE_NOP_EN
  localparam logic [INS_W-1:0] BUBBLE = INS_W'(IF_NOP_INST);
`else
  localparam logic [INS_W-1:0] BUBBLE = '0;
`endif

  logic [INS_ADDRESS-1:0] fetch_pc_q, fetch_pc_d;
  logic [INS_ADDRESS-1:0] infl_pc_q;
  logic                   infl_q;
  logic                   infl_ep_q;
  logic                   epoch_q, epoch_d;

  logic [1:0] q_count;
  logic [1:0] occ;
  logic       q_push, q_pop, issue;
  entry_t     q_head, q_in;

  // Slots still owed after this cycle's pop; a new request
  // is only made if its return is guaranteed a free slot.
  assign occ   = q_count + {1'b0, infl_q} - {1'b0, q_pop};
  assign q_pop = valid_out && !stall && !redirect_en;
  assign issue = !rst && !redirect_en && (occ < Q_FULL);

  // Wrong-path returns are dropped by epoch mismatch.
  assign q_push = infl_q && (infl_ep_q == epoch_q) && !redirect_en;
  assign q_in   = '{inst: imem_rdata, pc: infl_pc_q};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    epoch_d    = epoch_q;
    if (redirect_en) begin
      fetch_pc_d = redirect_pc;
      epoch_d    = ~epoch_q;
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + PC_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= '0;
      infl_q     <= 1'b0;
      infl_pc_q  <= '0;
      infl_ep_q  <= 1'b0;
      epoch_q    <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      infl_q     <= issue;
      infl_pc_q  <= fetch_pc_q;
      infl_ep_q  <= epoch_q;
      epoch_q    <= epoch_d;
    end
  end

  if_prefetch_q #(
    .W($bits(entry_t))
  ) u_q (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (q_push),
    .pop_i   (q_pop),
    .flush_i (redirect_en),
    .data_i  (q_in),
    .head_o  (q_head),
    .count_o (q_count)
  );

  assign imem_req  = issue;
  assign imem_addr = fetch_pc_q;
  assign valid_out = (q_count != 2'd0);
  assign PCout     = valid_out ? q_head.pc : '0;
  assign INSTout   = valid_out ? q_head.inst : BUBBLE;
endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: stream, stall, redirect,
// wrap and mid-stream reset, against mem[a] = a + 100.
module tb_if_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [8:0]  imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic        redirect_en = 1'b0;
  logic [8:0]  redirect_pc = '0;
  logic [31:0] INSTout;
  logic [8:0]  PCout;
  logic        valid_out;

  int pass_cnt = 0;
  int total = 0;

`ifdef IF_BUBBLE_NOP_EN
  localparam logic [31:0] BUB = 32'h0000_0013;
`else
  localparam logic [31:0] BUB = 32'h0;
`endif

  if_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .INSTout     (INSTout),
    .PCout       (PCout),
    .valid_out   (valid_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    imem_rdata <= imem_req ? {23'd0, imem_addr} + 32'd100 : 32'hDEAD_BEEF;

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (valid_out !== 1'b0) $display("FAIL rst_valid got=%0h exp=0", valid_out);
    else pass_cnt++;
    total++;
    if (PCout !== 9'h0) $display("FAIL rst_pc got=%0h exp=0", PCout);
    else pass_cnt++;
    total++;
    if (INSTout !== BUB) $display("FAIL rst_inst got=%0h exp=%0h", INSTout, BUB);
    else pass_cnt++;
    total++;
    if (imem_req !== 1'b0) $display("FAIL rst_req got=%0h exp=0", imem_req);
    else pass_cnt++;
    total++;
    if (imem_addr !== 9'h0) $display("FAIL rst_addr got=%0h exp=0", imem_addr);
    else pass_cnt++;
  endtask

  task automatic test_stream();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (valid_out !== 1'b0) $display("FAIL strm_bubble got=%0h exp=0", valid_out);
    else pass_cnt++;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 9'h1)
      $display("FAIL strm_req got=%0h/%0h exp=1/1", imem_req, imem_addr);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (valid_out !== 1'b1 || PCout !== 9'(i) || INSTout !== 32'(i + 100))
        $display("FAIL strm_%0d got=%0h/%0h/%0h exp=1/%0h/%0h",
                 i, valid_out, PCout, INSTout, i, i + 100);
      else pass_cnt++;
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (valid_out !== 1'b1 || PCout !== 9'h2 || INSTout !== 32'd102)
        $display("FAIL stall_hold_%0d got=%0h/%0h/%0h exp=1/2/66",
                 i, valid_out, PCout, INSTout);
      else pass_cnt++;
      total++;
      if (imem_req !== 1'b0) $display("FAIL stall_req_%0d got=%0h exp=0", i, imem_req);
      else pass_cnt++;
    end
    stall = 1'b0;
    for (int i = 3; i < 6; i++) begin
      @(negedge clk);
      total++;
      if (valid_out !== 1'b1 || PCout !== 9'(i) || INSTout !== 32'(i + 100))
        $display("FAIL stall_rel_%0d got=%0h/%0h/%0h exp=1/%0h/%0h",
                 i, valid_out, PCout, INSTout, i, i + 100);
      else pass_cnt++;
    end
  endtask

  task automatic redirect_tail(input string nm);
    @(negedge clk);
    redirect_en = 1'b0;
    stall = 1'b0;
    #1;
    total++;
    if (valid_out !== 1'b0) $display("FAIL %s_b1 got=%0h exp=0", nm, valid_out);
    else pass_cnt++;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 9'h040)
      $display("FAIL %s_req got=%0h/%0h exp=1/40", nm, imem_req, imem_addr);
    else pass_cnt++;
    @(negedge clk);
    total++;
    if (valid_out !== 1'b0) $display("FAIL %s_b2 got=%0h exp=0", nm, valid_out);
    else pass_cnt++;
    @(negedge clk);
    total++;
    if (valid_out !== 1'b1 || PCout !== 9'h040 || INSTout !== 32'd164)
      $display("FAIL %s_tgt got=%0h/%0h/%0h exp=1/40/a4", nm, valid_out, PCout, INSTout);
    else pass_cnt++;
    @(negedge clk);
    total++;
    if (valid_out !== 1'b1 || PCout !== 9'h041 || INSTout !== 32'd165)
      $display("FAIL %s_nxt got=%0h/%0h/%0h exp=1/41/a5", nm, valid_out, PCout, INSTout);
    else pass_cnt++;
  endtask

  task automatic test_redirect();
    redirect_en = 1'b1;
    redirect_pc = 9'h040;
    #1;
    total++;
    if (imem_req !== 1'b0) $display("FAIL redir_req0 got=%0h exp=0", imem_req);
    else pass_cnt++;
    redirect_tail("redir");
  endtask

  task automatic test_redirect_stall();
    stall = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (imem_req !== 1'b0 || PCout !== 9'h041)
      $display("FAIL rs_full got=%0h/%0h exp=0/41", imem_req, PCout);
    else pass_cnt++;
    redirect_en = 1'b1;
    redirect_pc = 9'h040;
    redirect_tail("rs");
  endtask

  task automatic test_wrap();
    logic [8:0] e;
    redirect_en = 1'b1;
    redirect_pc = 9'h1FE;
    @(negedge clk);
    redirect_en = 1'b0;
    @(negedge clk);
    e = 9'h1FE;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (valid_out !== 1'b1 || PCout !== e || INSTout !== {23'd0, e} + 32'd100)
        $display("FAIL wrap_%0d got=%0h/%0h/%0h exp=1/%0h/%0h",
                 i, valid_out, PCout, INSTout, e, {23'd0, e} + 32'd100);
      else pass_cnt++;
      e = e + 9'd1;
    end
  endtask

  task automatic test_rst_mid();
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (valid_out !== 1'b0 || PCout !== 9'h0 || INSTout !== BUB)
      $display("FAIL rmid_out got=%0h/%0h/%0h exp=0/0/%0h", valid_out, PCout, INSTout, BUB);
    else pass_cnt++;
    total++;
    if (imem_req !== 1'b0 || imem_addr !== 9'h0)
      $display("FAIL rmid_req got=%0h/%0h exp=0/0", imem_req, imem_addr);
    else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (valid_out !== 1'b0 || imem_addr !== 9'h1)
      $display("FAIL rmid_b got=%0h/%0h exp=0/1", valid_out, imem_addr);
    else pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (valid_out !== 1'b1 || PCout !== 9'(i) || INSTout !== 32'(i + 100))
        $display("FAIL rmid_%0d got=%0h/%0h/%0h exp=1/%0h/%0h",
                 i, valid_out, PCout, INSTout, i, i + 100);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_wrap();
    test_rst_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
